// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS MEM stage.
package mips_pkg;

  localparam int REG_ADDR_W      = 5;
  localparam int WORD_ALIGN_BITS = 2;
  localparam int DATA_W          = 32;

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } mem_state_t;

  // Registered write-back bundle handed to the WB stage.
  typedef struct packed {
    logic                  valid;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] write_reg;
    logic [DATA_W-1:0]     data;
  } wb_bundle_t;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts bus-access cycles that pass without an acknowledge.
// expired is asserted during the cycle that would be the TIMEOUT_CYCLES-th
// ack-less cycle, so the owner can abort on that same edge.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  // Cycle counter: cleared while idle, advanced on each ack-less access cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

  assign expired = enable && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/memory_access.sv
// MEM stage: performs loads/stores over a req/ack bus, resolves branches and
// delivers a registered write-back bundle, stalling upstream during bus access.
module memory_access
  import mips_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int ADDR_W         = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [ADDR_W-1:0]     ALU_result,
  input  logic [ADDR_W-1:0]     write_data,
  input  logic [ADDR_W-1:0]     new_address,
  input  logic                  zero,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  branch,
  input  logic                  reg_write_in,
  input  logic                  mem_to_reg_in,
  input  logic [REG_ADDR_W-1:0] write_reg_in,
  output logic                  stall,
  output logic                  pc_src,
  output logic [ADDR_W-1:0]     branch_target,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_W-1:0]     bus_addr,
  output logic [ADDR_W-1:0]     bus_wdata,
  input  logic                  bus_ack,
  input  logic [ADDR_W-1:0]     bus_rdata,
  output logic                  wb_valid,
  output logic                  wb_reg_write,
  output logic [REG_ADDR_W-1:0] wb_write_reg,
  output logic [ADDR_W-1:0]     wb_data,
  output logic                  fault
);

  mem_state_t state_reg, state_next;
  wb_bundle_t wb_reg, wb_next;
  logic       bus_req_next;
  logic       fault_next;

  // Op attributes captured at the accept edge, used when the access completes.
  logic                  cap_store;
  logic                  cap_load_to_reg;
  logic                  cap_reg_write;
  logic [REG_ADDR_W-1:0] cap_write_reg;
  logic [ADDR_W-1:0]     cap_alu;

  logic accept;
  logic is_mem;
  logic aligned;
  logic timer_clear;
  logic timer_enable;
  logic timer_expired;

  assign accept       = (state_reg == IDLE) && valid_in;
  assign is_mem       = mem_read | mem_write;
  assign aligned      = (ALU_result[WORD_ALIGN_BITS-1:0] == '0);
  assign stall        = (state_reg != IDLE);
  assign timer_clear  = (state_reg == IDLE);
  assign timer_enable = (state_reg == ACCESS) && !bus_ack;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (timer_clear),
    .enable  (timer_enable),
    .expired (timer_expired)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state, bus request, fault and write-back bundle decisions.
  always_comb begin
    state_next        = state_reg;
    bus_req_next      = bus_req;
    fault_next        = 1'b0;
    wb_next           = wb_reg;
    wb_next.valid     = 1'b0;
    if (state_reg == IDLE) begin
      if (valid_in) begin
        if (is_mem && aligned) begin
          state_next   = ACCESS;
          bus_req_next = 1'b1;
        end else if (is_mem) begin
          // Misaligned: report and retire without touching the bus.
          fault_next        = 1'b1;
          wb_next.valid     = 1'b1;
          wb_next.reg_write = 1'b0;
          wb_next.write_reg = write_reg_in;
          wb_next.data      = ALU_result;
        end else begin
          wb_next.valid     = 1'b1;
          wb_next.reg_write = reg_write_in;
          wb_next.write_reg = write_reg_in;
          wb_next.data      = ALU_result;
        end
      end
    end else begin
      // An ack in the final allowed cycle takes priority over the timeout.
      if (bus_ack) begin
        state_next        = IDLE;
        bus_req_next      = 1'b0;
        wb_next.valid     = 1'b1;
        wb_next.reg_write = cap_reg_write & ~cap_store;
        wb_next.write_reg = cap_write_reg;
        wb_next.data      = cap_load_to_reg ? bus_rdata : cap_alu;
      end else if (timer_expired) begin
        state_next        = IDLE;
        bus_req_next      = 1'b0;
        fault_next        = 1'b1;
        wb_next.valid     = 1'b1;
        wb_next.reg_write = 1'b0;
        wb_next.write_reg = cap_write_reg;
        wb_next.data      = cap_alu;
      end
    end
  end

  // Output, bus and capture registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_reg          <= '0;
      bus_req         <= 1'b0;
      bus_we          <= 1'b0;
      bus_addr        <= '0;
      bus_wdata       <= '0;
      fault           <= 1'b0;
      pc_src          <= 1'b0;
      branch_target   <= '0;
      cap_store       <= 1'b0;
      cap_load_to_reg <= 1'b0;
      cap_reg_write   <= 1'b0;
      cap_write_reg   <= '0;
      cap_alu         <= '0;
    end else begin
      wb_reg  <= wb_next;
      bus_req <= bus_req_next;
      fault   <= fault_next;
      pc_src  <= accept & branch & zero;
      if (accept && branch) begin
        branch_target <= new_address;
      end
      if (accept && is_mem && aligned) begin
        bus_we    <= mem_write;
        bus_addr  <= ALU_result;
        bus_wdata <= write_data;
      end
      if (accept) begin
        cap_store       <= mem_write;
        cap_load_to_reg <= mem_read & ~mem_write & mem_to_reg_in;
        cap_reg_write   <= reg_write_in;
        cap_write_reg   <= write_reg_in;
        cap_alu         <= ALU_result;
      end
    end
  end

  assign wb_valid     = wb_reg.valid;
  assign wb_reg_write = wb_reg.reg_write;
  assign wb_write_reg = wb_reg.write_reg;
  assign wb_data      = wb_reg.data;

endmodule

// File: tb/tb_memory_access.sv
// Randomized + directed bench for memory_access with an op-level reference model.
module tb_memory_access;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [31:0] ALU_result = '0, write_data = '0, new_address = '0;
  logic        zero = 1'b0, mem_read = 1'b0, mem_write = 1'b0, branch = 1'b0;
  logic        reg_write_in = 1'b0, mem_to_reg_in = 1'b0;
  logic [4:0]  write_reg_in = '0;
  logic        stall, pc_src, bus_req, bus_we, wb_valid, wb_reg_write, fault;
  logic [31:0] branch_target, bus_addr, bus_wdata, wb_data;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [4:0]  wb_write_reg;

  always #5 clk = ~clk;

  memory_access #(.TIMEOUT_CYCLES(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ALU_result(ALU_result),
    .write_data(write_data), .new_address(new_address), .zero(zero),
    .mem_read(mem_read), .mem_write(mem_write), .branch(branch),
    .reg_write_in(reg_write_in), .mem_to_reg_in(mem_to_reg_in),
    .write_reg_in(write_reg_in), .stall(stall), .pc_src(pc_src),
    .branch_target(branch_target), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata), .wb_valid(wb_valid), .wb_reg_write(wb_reg_write),
    .wb_write_reg(wb_write_reg), .wb_data(wb_data), .fault(fault)
  );

  int n_vec = 0;
  int n_err = 0;

  // Expected outputs for the current cycle, maintained by the driver.
  logic        e_stall, e_req, e_we, e_wbv, e_wbrw, e_pc, e_fault, e_known;
  logic [31:0] e_addr, e_wdata, e_wbd, e_bt;
  logic [4:0]  e_wbr;
  logic        chk_en = 1'b0;

  // Observation counters for literal expectations on directed tests.
  int          req_cnt, stall_cnt, wbv_cnt, fault_cnt, pc_cnt;
  logic [31:0] last_addr, last_wdata, last_wbd;
  logic        last_we, last_wbrw;
  logic [4:0]  last_wbr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Cycle-by-cycle compare against the model.
  always @(negedge clk) begin
    if (chk_en && rst_n) begin
      chk("stall", {31'd0, stall}, {31'd0, e_stall});
      chk("bus_req", {31'd0, bus_req}, {31'd0, e_req});
      if (e_req) begin
        chk("bus_we", {31'd0, bus_we}, {31'd0, e_we});
        chk("bus_addr", bus_addr, e_addr);
        chk("bus_wdata", bus_wdata, e_wdata);
      end
      chk("wb_valid", {31'd0, wb_valid}, {31'd0, e_wbv});
      chk("wb_reg_write", {31'd0, wb_reg_write}, {31'd0, e_wbrw});
      chk("fault", {31'd0, fault}, {31'd0, e_fault});
      chk("pc_src", {31'd0, pc_src}, {31'd0, e_pc});
      chk("branch_target", branch_target, e_bt);
      if (e_known) begin
        chk("wb_write_reg", {27'd0, wb_write_reg}, {27'd0, e_wbr});
        chk("wb_data", wb_data, e_wbd);
      end
    end
  end

  // Observation monitor.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus_req) begin
        req_cnt++; last_addr = bus_addr; last_we = bus_we; last_wdata = bus_wdata;
      end
      if (stall) stall_cnt++;
      if (wb_valid) begin
        wbv_cnt++; last_wbd = wb_data; last_wbrw = wb_reg_write; last_wbr = wb_write_reg;
      end
      if (fault) fault_cnt++;
      if (pc_src) pc_cnt++;
    end
  end

  task automatic clear_mon();
    req_cnt = 0; stall_cnt = 0; wbv_cnt = 0; fault_cnt = 0; pc_cnt = 0;
  endtask

  task automatic model_reset();
    e_stall = 0; e_req = 0; e_we = 0; e_wbv = 0; e_wbrw = 0; e_pc = 0; e_fault = 0;
    e_known = 1; e_addr = 0; e_wdata = 0; e_wbd = 0; e_bt = 0; e_wbr = 0;
  endtask

  // Advance to just after the next rising edge; one-cycle pulses default low.
  task automatic tick();
    @(posedge clk);
    #1;
    e_wbv = 0; e_fault = 0; e_pc = 0;
  endtask

  task automatic garbage();
    valid_in = 1'($urandom_range(0, 1));
    ALU_result = $urandom; write_data = $urandom; new_address = $urandom;
    zero = 1'($urandom_range(0, 1)); branch = 1'($urandom_range(0, 1));
    mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
    reg_write_in = 1'($urandom_range(0, 1)); mem_to_reg_in = 1'($urandom_range(0, 1));
    write_reg_in = 5'($urandom);
  endtask

  // Apply one op (called just after a rising edge with the DUT idle).
  // ack_dly: access cycles until ack; 0 means the bus never answers.
  task automatic do_op(input logic rd, input logic wr, input logic br, input logic z,
                       input logic rw, input logic m2r, input logic [4:0] wreg,
                       input logic [31:0] alu, input logic [31:0] wd,
                       input logic [31:0] na, input int ack_dly,
                       input logic [31:0] rdata, input int gap);
    bit acked;
    int n;
    valid_in = 1; mem_read = rd; mem_write = wr; branch = br; zero = z;
    reg_write_in = rw; mem_to_reg_in = m2r; write_reg_in = wreg;
    ALU_result = alu; write_data = wd; new_address = na;
    bus_ack = 1'($urandom_range(0, 1));
    bus_rdata = $urandom;
    tick();
    e_pc = br & z;
    if (br) e_bt = na;
    if (!(rd | wr)) begin
      valid_in = 0; bus_ack = 1'($urandom_range(0, 1));
      e_wbv = 1; e_wbrw = rw; e_wbr = wreg; e_wbd = alu; e_known = 1;
    end else if (alu[1:0] != 2'b00) begin
      valid_in = 0; bus_ack = 1'($urandom_range(0, 1));
      e_wbv = 1; e_wbrw = 0; e_fault = 1; e_known = 0;
    end else begin
      acked = (ack_dly >= 1) && (ack_dly <= TO);
      n = acked ? ack_dly : TO;
      e_stall = 1; e_req = 1; e_we = wr; e_addr = alu; e_wdata = wd;
      for (int k = 1; k <= n; k++) begin
        garbage();
        bus_rdata = (k == n) ? rdata : $urandom;
        bus_ack = acked && (k == n);
        tick();
      end
      valid_in = 0; bus_ack = 1'($urandom_range(0, 1)); bus_rdata = $urandom;
      e_stall = 0; e_req = 0; e_wbv = 1;
      if (acked) begin
        e_wbrw = rw & ~wr; e_wbr = wreg; e_wbd = (rd & ~wr & m2r) ? rdata : alu; e_known = 1;
      end else begin
        e_wbrw = 0; e_fault = 1; e_known = 0;
      end
    end
    $display("op rd=%0d wr=%0d br=%0d z=%0d addr=%h ack_dly=%0d -> wbrw=%0d fault=%0d",
             rd, wr, br, z, alu, ack_dly, e_wbrw, e_fault);
    for (int g = 0; g < gap; g++) begin
      bus_ack = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Let the last pulse be observed, then realign to just after a rising edge.
  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] alu;
    logic        rd, wr;
    int          kind, sel, dly;

    model_reset();
    clear_mon();
    #2;
    chk("reset_bus_req", {31'd0, bus_req}, 32'd0);
    chk("reset_stall", {31'd0, stall}, 32'd0);
    chk("reset_bus_addr", bus_addr, 32'd0);
    chk("reset_bus_wdata", bus_wdata, 32'd0);
    chk("reset_wb_data", wb_data, 32'd0);
    chk("reset_branch_target", branch_target, 32'd0);
    chk("reset_wb_valid", {31'd0, wb_valid}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;
    chk_en = 1;
    tick();

    // R-type pass-through
    clear_mon();
    do_op(0, 0, 0, 0, 1, 0, 5'd9, 32'h2A, 32'h0, 32'h0, 0, 32'h0, 0);
    settle();
    chk("rtype_wb_data", last_wbd, 32'h2A);
    chk("rtype_wb_reg", {27'd0, last_wbr}, 32'd9);
    chk("rtype_stall_cycles", stall_cnt, 0);
    chk("rtype_wb_count", wbv_cnt, 1);
    tick();

    // Load, ack in third access cycle
    clear_mon();
    do_op(1, 0, 0, 0, 1, 1, 5'd4, 32'h100, 32'h0, 32'h0, 3, 32'hDEADBEEF, 0);
    settle();
    chk("load_req_cycles", req_cnt, 3);
    chk("load_stall_cycles", stall_cnt, 3);
    chk("load_bus_addr", last_addr, 32'h100);
    chk("load_bus_we", {31'd0, last_we}, 32'd0);
    chk("load_wb_data", last_wbd, 32'hDEADBEEF);
    tick();

    // Store, ack after one cycle
    clear_mon();
    do_op(0, 1, 0, 0, 1, 0, 5'd7, 32'h200, 32'h1234, 32'h0, 1, 32'h0, 0);
    settle();
    chk("store_bus_we", {31'd0, last_we}, 32'd1);
    chk("store_bus_wdata", last_wdata, 32'h1234);
    chk("store_wb_reg_write", {31'd0, last_wbrw}, 32'd0);
    chk("store_wb_count", wbv_cnt, 1);
    tick();

    // Branch taken, then not taken
    clear_mon();
    do_op(0, 0, 1, 1, 0, 0, 5'd0, 32'h0, 32'h0, 32'h40, 0, 32'h0, 0);
    settle();
    chk("branch_taken_pulses", pc_cnt, 1);
    chk("branch_target_lit", branch_target, 32'h40);
    tick();
    clear_mon();
    do_op(0, 0, 1, 0, 0, 0, 5'd0, 32'h0, 32'h0, 32'h80, 0, 32'h0, 1);
    settle();
    chk("branch_not_taken_pulses", pc_cnt, 0);
    tick();

    // Misaligned load
    clear_mon();
    do_op(1, 0, 0, 0, 1, 1, 5'd2, 32'h102, 32'h0, 32'h0, 1, 32'h0, 0);
    settle();
    chk("misaligned_req_cycles", req_cnt, 0);
    chk("misaligned_fault", fault_cnt, 1);
    chk("misaligned_wb_reg_write", {31'd0, last_wbrw}, 32'd0);
    tick();

    // Load with no ack: timeout
    clear_mon();
    do_op(1, 0, 0, 0, 1, 1, 5'd5, 32'h400, 32'h0, 32'h0, 0, 32'h0, 0);
    settle();
    chk("timeout_req_cycles", req_cnt, TO);
    chk("timeout_fault", fault_cnt, 1);
    chk("timeout_wb_reg_write", {31'd0, last_wbrw}, 32'd0);
    tick();

    // Ack on the final allowed cycle wins over timeout
    clear_mon();
    do_op(1, 0, 0, 0, 1, 1, 5'd6, 32'h500, 32'h0, 32'h0, TO, 32'hCAFE0001, 0);
    settle();
    chk("edge_ack_fault", fault_cnt, 0);
    chk("edge_ack_wb_data", last_wbd, 32'hCAFE0001);
    tick();

    // Async reset in the middle of an access
    clear_mon();
    valid_in = 1; mem_read = 1; mem_write = 0; branch = 0; zero = 0;
    reg_write_in = 1; mem_to_reg_in = 1; write_reg_in = 5'd3;
    ALU_result = 32'h300; write_data = 32'h55; bus_ack = 0;
    tick();
    valid_in = 0;
    e_stall = 1; e_req = 1; e_we = 0; e_addr = 32'h300; e_wdata = 32'h55;
    tick();
    #2;
    rst_n = 0;
    #1;
    chk("async_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("async_rst_stall", {31'd0, stall}, 32'd0);
    chk("async_rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    model_reset();
    tick();
    tick();
    rst_n = 1;
    tick();
    chk("post_rst_wb_count", wbv_cnt, 0);
    clear_mon();
    do_op(0, 0, 0, 0, 1, 0, 5'd11, 32'h77, 32'h0, 32'h0, 0, 32'h0, 0);
    settle();
    chk("post_rst_rtype_data", last_wbd, 32'h77);
    chk("post_rst_rtype_reg", {27'd0, last_wbr}, 32'd11);
    tick();

    // Randomized ops
    for (int i = 0; i < 150; i++) begin
      kind = $urandom_range(0, 9);
      rd = 0; wr = 0;
      if (kind >= 3 && kind < 6) rd = 1;
      else if (kind >= 6 && kind < 8) wr = 1;
      else if (kind == 8) begin rd = 1; wr = 1; end
      alu = $urandom;
      if ((rd | wr) && ($urandom_range(0, 5) != 0)) alu[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      if (sel == 0) dly = 0;
      else if (sel == 1) dly = TO;
      else if (sel == 2) dly = TO + 1;
      else dly = $urandom_range(1, 6);
      do_op(rd, wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom),
            alu, $urandom, $urandom, dly, $urandom, $urandom_range(0, 2));
    end
    tick();

    chk_en = 0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/memory_access.md
Name: memory_access

Overview:
- MEM stage of the MIPS datapath, directly downstream of the execute stage.
- Consumes the execute stage's ALU result, store data, branch target and zero flag, together with the control bits that are pipelined alongside them.
- Performs loads and stores over a req/ack data bus, which may take several cycles, and resolves branches.
- Delivers a registered write-back bundle and stalls upstream while a bus access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 16: maximum number of ACCESS cycles without bus_ack before the access is aborted.
- ADDR_W, 32: width of the address and data paths.

Ports:
- clk  in  1  : system clock, rising edge.
- rst_n  in  1  : asynchronous active-low reset.
- valid_in  in  1  : execute-stage outputs are valid this cycle.
- ALU_result  in  32  : effective address for memory ops; result value otherwise.
- write_data  in  32  : store data (rt register value).
- new_address  in  32  : branch target.
- zero  in  1  : ALU zero flag.
- mem_read  in  1  : load.
- mem_write  in  1  : store.
- branch  in  1  : beq.
- reg_write_in  in  1  : write-back enable.
- mem_to_reg_in  in  1  : write-back data comes from the load.
- write_reg_in  in  5  : destination register.
- stall  out  1  : upstream must hold its outputs; inputs are ignored.
- pc_src  out  1  : take the branch.
- branch_target  out  32  : PC to load when pc_src=1.
- bus_req  out  1, bus_we  out  1, bus_addr  out  32, bus_wdata  out  32 : data bus request.
- bus_ack  in  1, bus_rdata  in  32 : data bus completion and read data.
- wb_valid  out  1, wb_reg_write  out  1, wb_write_reg  out  5, wb_data  out  32 : write-back bundle.
- fault  out  1  : one-cycle pulse on misalignment or bus timeout.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; timeout counter=0.
  - All outputs 0, including bus_addr, bus_wdata, wb_data and branch_target.
- Inputs are sampled only when state==IDLE and valid_in=1; this is the accept edge.
- stall = (state != IDLE), driven combinationally from the state register.
- FSM states: IDLE, ACCESS.
- Non-memory op (mem_read=mem_write=0), accepted in IDLE:
  - Next edge: wb_valid=1, wb_reg_write=reg_write_in, wb_write_reg=write_reg_in, wb_data=ALU_result.
  - Latency 1 cycle; no stall.
- Branch:
  - At the accept edge, pc_src <= branch & zero and branch_target <= new_address.
  - pc_src is a one-cycle pulse; branch_target holds its value until the next branch.
- Memory op with ALU_result[1:0]==0:
  - IDLE -> ACCESS at the accept edge.
  - bus_req=1, bus_addr=ALU_result and bus_we=mem_write are registered at that edge.
  - bus_wdata=write_data is registered at that edge.
  - All of these are held constant until completion.
- In ACCESS, if bus_ack=1 at an edge:
  - bus_req <= 0; state -> IDLE.
  - wb_valid <= 1 and wb_write_reg <= captured write_reg_in.
  - wb_reg_write <= captured reg_write_in & ~mem_write.
  - wb_data <= bus_rdata if load with mem_to_reg_in=1, else the captured ALU_result.
  - Load latency = ack wait + 1 cycles after accept. Stall is high from the accept edge through the ack cycle.
- Timeout:
  - The counter increments for each ACCESS cycle without bus_ack.
  - When it reaches TIMEOUT_CYCLES: bus_req <= 0, fault pulse, wb_valid=1 with wb_reg_write=0, state -> IDLE.
  - bus_ack arriving in the same cycle as the timeout wins; no fault is raised.
- Misaligned memory op (ALU_result[1:0]!=0):
  - No bus request; stays in IDLE.
  - Next edge: fault=1 and wb_valid=1 with wb_reg_write=0.
- mem_read and mem_write both set: treated as a store, with wb_reg_write forced to 0.
- wb_valid is a one-cycle pulse per accepted op. Idle cycles produce wb_valid=0 and leave the other wb_* fields unchanged.
- bus_ack while in IDLE is ignored.
- Reset asserted mid-ACCESS: bus_req drops immediately (async), the in-flight op is discarded and no wb_valid is produced.

Decomposition:
- Shared package (mips_pkg):
  - typedef mem_state_t {IDLE, ACCESS}.
  - Struct for the write-back bundle.
  - Constants REG_ADDR_W=5 and WORD_ALIGN_BITS=2.
- Sub-module mem_timeout_counter: counter with clear/enable inputs and an expired output, parameterised by TIMEOUT_CYCLES.
- The rest stays flat.

Test Plan:
- R-type pass-through: ALU_result=0x0000_002A, reg_write_in=1, write_reg_in=9 -> next cycle wb_valid=1, wb_data=0x2A, wb_write_reg=9; stall stays 0.
- Load, ack after 3 cycles: ALU_result=0x100, bus_rdata=0xDEADBEEF, mem_to_reg_in=1.
  - Required: bus_req high for 3 cycles with bus_addr=0x100, bus_we=0; stall high for 3 cycles.
  - Required: wb_data=0xDEADBEEF on the cycle after ack.
- Store: write_data=0x1234, ALU_result=0x200, ack after 1 cycle -> bus_we=1, bus_wdata=0x1234; wb_valid=1 with wb_reg_write=0.
- Branch taken/not taken: branch=1, zero=1, new_address=0x40 -> pc_src pulse, branch_target=0x40; with zero=0 -> pc_src stays 0.
- Faults:
  - Misaligned load at 0x102 -> no bus_req, fault pulse.
  - Load with no ack -> bus_req drops after 16 cycles, fault pulse, wb_reg_write=0.
- Async reset mid-ACCESS -> bus_req=0 and stall=0 immediately, with no wb_valid; after release, the next R-type op completes normally.
